// File: rtl/ascon_fsm_if.sv
// ----------------------------------------------------------------------------
// ascon_fsm_if
// Control bundle between the ASCON sequencing FSM and its datapath.
//   master : the FSM side. Receives start_i / data_valid_i and drives every
//            datapath enable, the round index and the status flags.
//   slave  : the datapath / host side. Drives start_i / data_valid_i and
//            observes the enables and status flags.
// Signals:
//   start_i           begin a new encryption
//   data_valid_i      next AD/plaintext block present on the datapath input
//   data_sel_o        0 = external initial state, 1 = registered state
//   en_reg_state_o    permutation state register enable
//   en_xor_data_o     XOR data into state word 0 at permutation input
//   en_xor_key_o      XOR key into state words 1-2 at permutation input
//   en_xor_lsb_o      XOR 1 into state word 4 LSB at permutation output
//   en_xor_key_end_o  XOR key into state words 3-4 at permutation output
//   counter_o         round index for the round-constant input
//   en_cipher_o       cipher register load enable
//   en_tag_o          tag register load enable
//   cipher_valid_o    cipher register content valid (one-cycle pulse)
//   end_o             encryption complete, tag valid
// ----------------------------------------------------------------------------
interface ascon_fsm_if;
    logic       start_i;
    logic       data_valid_i;
    logic       data_sel_o;
    logic       en_reg_state_o;
    logic       en_xor_data_o;
    logic       en_xor_key_o;
    logic       en_xor_lsb_o;
    logic       en_xor_key_end_o;
    logic [3:0] counter_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic       cipher_valid_o;
    logic       end_o;

    modport master (
        input  start_i,
        input  data_valid_i,
        output data_sel_o,
        output en_reg_state_o,
        output en_xor_data_o,
        output en_xor_key_o,
        output en_xor_lsb_o,
        output en_xor_key_end_o,
        output counter_o,
        output en_cipher_o,
        output en_tag_o,
        output cipher_valid_o,
        output end_o
    );

    modport slave (
        output start_i,
        output data_valid_i,
        input  data_sel_o,
        input  en_reg_state_o,
        input  en_xor_data_o,
        input  en_xor_key_o,
        input  en_xor_lsb_o,
        input  en_xor_key_end_o,
        input  counter_o,
        input  en_cipher_o,
        input  en_tag_o,
        input  cipher_valid_o,
        input  end_o
    );
endinterface

// File: rtl/ascon_fsm.sv
// ----------------------------------------------------------------------------
// ascon_fsm
// Sequencing FSM for an iterative ASCON encryption datapath (one permutation
// round per clock). Runs a message of N_BLOCKS 64-bit plaintext blocks with a
// single associated-data block:
//   INIT (12 rounds) -> WAIT_AD -> AD (6 rounds) ->
//   { WAIT_PT -> PT (6 rounds) } x (N_BLOCKS-1) -> WAIT_PT -> FIN (12 rounds)
//   -> END
// The last plaintext block is absorbed at the start of FIN, together with the
// finalisation key XOR, so only N_BLOCKS-1 PT phases are run.
// All datapath controls are Moore outputs decoded from the registered state,
// round counter and block counter; cipher_valid_o is the only registered
// output (the cycle after each cipher load).
// Ports:
//   clock_i   clock, all state updates on the rising edge
//   resetb_i  asynchronous active-low reset: IDLE, counters 0, outputs 0
//   bus       ascon_fsm_if.master control bundle (see interface header)
// Parameter:
//   N_BLOCKS  plaintext blocks per message, 1..15
// ----------------------------------------------------------------------------
module ascon_fsm #(
    parameter int N_BLOCKS = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    ascon_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT_AD = 3'd2,
        ST_AD      = 3'd3,
        ST_WAIT_PT = 3'd4,
        ST_PT      = 3'd5,
        ST_FIN     = 3'd6,
        ST_END     = 3'd7
    } state_t;

    localparam logic [3:0] ROUND_FIRST = 4'd0;
    localparam logic [3:0] ROUND_HALF  = 4'd6;   // first round of a 6-round phase
    localparam logic [3:0] ROUND_LAST  = 4'd11;
    localparam logic [3:0] LAST_BLOCK  = 4'(N_BLOCKS - 1);

    state_t     state_reg, state_next;
    logic [3:0] round_reg, round_next;
    logic [3:0] block_reg, block_next;
    logic       cipher_valid_reg;

    logic       round_first;
    logic       round_half;
    logic       round_last;

    // decoded outputs
    logic       data_sel;
    logic       en_reg_state;
    logic       en_xor_data;
    logic       en_xor_key;
    logic       en_xor_lsb;
    logic       en_xor_key_end;
    logic       en_cipher;
    logic       en_tag;
    logic       end_flag;

    assign round_first = (round_reg == ROUND_FIRST);
    assign round_half  = (round_reg == ROUND_HALF);
    assign round_last  = (round_reg == ROUND_LAST);

    // ------------------------------------------------------------------------
    // State, counters and the delayed cipher-valid flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_reg        <= ST_IDLE;
            round_reg        <= 4'd0;
            block_reg        <= 4'd0;
            cipher_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            round_reg        <= round_next;
            block_reg        <= block_next;
            // The cipher register is loaded on the en_cipher cycle, so its
            // content is valid one cycle later.
            cipher_valid_reg <= en_cipher;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        round_next     = round_reg;
        block_next     = block_reg;
        data_sel       = 1'b0;
        en_reg_state   = 1'b0;
        en_xor_data    = 1'b0;
        en_xor_key     = 1'b0;
        en_xor_lsb     = 1'b0;
        en_xor_key_end = 1'b0;
        en_cipher      = 1'b0;
        en_tag         = 1'b0;
        end_flag       = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_next = ST_INIT;
                    round_next = ROUND_FIRST;
                    block_next = 4'd0;
                end
            end

            ST_INIT: begin
                en_reg_state = 1'b1;
                // First round takes the externally built initial state.
                data_sel       = !round_first;
                en_xor_key_end = round_last;
                if (round_last) begin
                    // Round counter is held at 11 while waiting.
                    state_next = ST_WAIT_AD;
                end else begin
                    round_next = round_reg + 4'd1;
                end
            end

            ST_WAIT_AD: begin
                if (bus.data_valid_i) begin
                    state_next = ST_AD;
                    round_next = ROUND_HALF;
                end
            end

            ST_AD: begin
                data_sel     = 1'b1;
                en_reg_state = 1'b1;
                en_xor_data  = round_half;
                // Domain separation bit after the last AD round.
                en_xor_lsb   = round_last;
                if (round_last) begin
                    state_next = ST_WAIT_PT;
                end else begin
                    round_next = round_reg + 4'd1;
                end
            end

            ST_WAIT_PT: begin
                if (bus.data_valid_i) begin
                    // The final block goes straight into finalisation.
                    if (block_reg == LAST_BLOCK) begin
                        state_next = ST_FIN;
                        round_next = ROUND_FIRST;
                    end else begin
                        state_next = ST_PT;
                        round_next = ROUND_HALF;
                    end
                end
            end

            ST_PT: begin
                data_sel     = 1'b1;
                en_reg_state = 1'b1;
                en_xor_data  = round_half;
                en_cipher    = round_half;
                if (round_last) begin
                    state_next = ST_WAIT_PT;
                    block_next = block_reg + 4'd1;
                end else begin
                    round_next = round_reg + 4'd1;
                end
            end

            ST_FIN: begin
                data_sel       = 1'b1;
                en_reg_state   = 1'b1;
                en_xor_data    = round_first;
                en_xor_key     = round_first;
                en_cipher      = round_first;
                en_xor_key_end = round_last;
                en_tag         = round_last;
                if (round_last) begin
                    state_next = ST_END;
                end else begin
                    round_next = round_reg + 4'd1;
                end
            end

            ST_END: begin
                end_flag = 1'b1;
                if (bus.start_i) begin
                    state_next = ST_INIT;
                    round_next = ROUND_FIRST;
                    block_next = 4'd0;
                end
            end

            default: begin
                state_next = ST_IDLE;
                round_next = 4'd0;
                block_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.data_sel_o       = data_sel;
    assign bus.en_reg_state_o   = en_reg_state;
    assign bus.en_xor_data_o    = en_xor_data;
    assign bus.en_xor_key_o     = en_xor_key;
    assign bus.en_xor_lsb_o     = en_xor_lsb;
    assign bus.en_xor_key_end_o = en_xor_key_end;
    assign bus.counter_o        = round_reg;
    assign bus.en_cipher_o      = en_cipher;
    assign bus.en_tag_o         = en_tag;
    assign bus.cipher_valid_o   = cipher_valid_reg;
    assign bus.end_o            = end_flag;

endmodule

// File: tb/tb_ascon_fsm.sv
// ----------------------------------------------------------------------------
// tb_ascon_fsm
// Two instances (N_BLOCKS=4 and N_BLOCKS=1) driven with identical stimulus.
// The reference model expands the phase schedule of a message (12 INIT
// rounds, wait, 6 AD rounds, waits and 6-round PT phases, 12 FIN rounds,
// END) into an expected per-cycle output trace, consuming the data_valid
// sequence wherever a wait phase occurs.
// Vector layout: [13] data_sel [12] en_reg_state [11] xor_data [10] xor_key
// [9] xor_lsb [8] xor_key_end [7:4] counter [3] en_cipher [2] en_tag
// [1] cipher_valid [0] end
// ----------------------------------------------------------------------------
module tb_ascon_fsm;

    localparam int MAXC = 160;
    localparam logic [13:0] M_WAIT = 14'b10_0000_1111_0000;
    localparam logic [13:0] M_END  = 14'b00_0000_1111_0000;

    logic clock_i = 1'b0;
    logic resetb_i;

    always #5 clock_i = ~clock_i;

    ascon_fsm_if if4();
    ascon_fsm_if if1();

    ascon_fsm #(.N_BLOCKS(4)) dut4 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(if4.master));
    ascon_fsm #(.N_BLOCKS(1)) dut1 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(if1.master));

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_tr   [2][MAXC];
    logic [13:0] exp_mask [2][MAXC];
    bit          is_wait  [2][MAXC];
    bit          dv_seq   [MAXC];
    int          fin_end  [2];
    logic [13:0] prev_obs [2];
    logic [13:0] first_obs[2];
    int          cv_q0[$];
    int          cv_q1[$];
    int          tag_cyc[2];
    int          end_cyc[2];

    function automatic logic [13:0] pack(input bit ds, input bit er, input bit xd,
                                         input bit xk, input bit xl, input bit xke,
                                         input int cnt, input bit ec, input bit et,
                                         input bit en);
        return {ds, er, xd, xk, xl, xke, 4'(cnt), ec, et, 1'b0, en};
    endfunction

    function automatic logic [13:0] obs(input int id);
        if (id == 0)
            return {if4.data_sel_o, if4.en_reg_state_o, if4.en_xor_data_o, if4.en_xor_key_o,
                    if4.en_xor_lsb_o, if4.en_xor_key_end_o, if4.counter_o, if4.en_cipher_o,
                    if4.en_tag_o, if4.cipher_valid_o, if4.end_o};
        else
            return {if1.data_sel_o, if1.en_reg_state_o, if1.en_xor_data_o, if1.en_xor_key_o,
                    if1.en_xor_lsb_o, if1.en_xor_key_end_o, if1.counter_o, if1.en_cipher_o,
                    if1.en_tag_o, if1.cipher_valid_o, if1.end_o};
    endfunction

    // Expand the message schedule into the expected trace for one instance.
    task automatic build(input int id, input int nb);
        int c;
        int blk;
        for (int i = 0; i < MAXC; i++) begin
            exp_tr[id][i]   = '0;
            exp_mask[id][i] = '0;
            is_wait[id][i]  = 1'b0;
        end
        c = 1;
        for (int r = 0; r < 12; r++) begin
            exp_tr[id][c] = pack(r != 0, 1, 0, 0, 0, r == 11, r, 0, 0, 0);
            c++;
        end
        do begin
            exp_mask[id][c] = M_WAIT;
            is_wait[id][c]  = 1'b1;
            c++;
        end while (!dv_seq[c-1]);
        for (int r = 6; r < 12; r++) begin
            exp_tr[id][c] = pack(1, 1, r == 6, 0, r == 11, 0, r, 0, 0, 0);
            c++;
        end
        blk = 0;
        forever begin
            do begin
                exp_mask[id][c] = M_WAIT;
                is_wait[id][c]  = 1'b1;
                c++;
            end while (!dv_seq[c-1]);
            if (blk == nb - 1) break;
            for (int r = 6; r < 12; r++) begin
                exp_tr[id][c] = pack(1, 1, r == 6, 0, 0, 0, r, r == 6, 0, 0);
                c++;
            end
            blk++;
        end
        for (int r = 0; r < 12; r++) begin
            exp_tr[id][c] = pack(1, 1, r == 0, r == 0, 0, r == 11, r, r == 0, r == 11, 0);
            c++;
        end
        fin_end[id] = c - 1;
        for (; c < MAXC; c++) begin
            exp_tr[id][c]   = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            exp_mask[id][c] = M_END;
        end
        // cipher_valid follows every cipher load by one cycle
        for (int i = MAXC - 1; i >= 1; i--)
            exp_tr[id][i][1] = exp_tr[id][i-1][3];
    endtask

    // Run one message from IDLE or END. mode 0: data_valid held 1, mode 1:
    // random. Optional 5-cycle data_valid stall, start pulse window, and an
    // asynchronous reset at cycle abort_at.
    task automatic run_msg(input int mode, input int stall_at, input int sp_lo,
                           input int sp_hi, input int end_cycles, input int abort_at);
        int len;
        logic [13:0] got;
        for (int k = 0; k < MAXC; k++) begin
            dv_seq[k] = (mode == 1 && k < 100) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (k >= stall_at && k < stall_at + 5) dv_seq[k] = 1'b0;
        end
        build(0, 4);
        build(1, 1);
        len = ((fin_end[0] > fin_end[1]) ? fin_end[0] : fin_end[1]) + end_cycles;
        cv_q0.delete();
        cv_q1.delete();
        tag_cyc = '{-1, -1};
        end_cyc = '{-1, -1};
        @(negedge clock_i);
        if4.start_i = 1'b1;      if1.start_i = 1'b1;
        if4.data_valid_i = dv_seq[0]; if1.data_valid_i = dv_seq[0];
        for (int k = 1; k <= len; k++) begin
            @(negedge clock_i);
            for (int id = 0; id < 2; id++) begin
                got = obs(id);
                if (k == 1) first_obs[id] = got;
                checks++;
                if (((got ^ exp_tr[id][k]) & ~exp_mask[id][k]) !== 14'd0) begin
                    errors++;
                    $display("FAIL trace dut%0d cycle %0d got %h expected %h (mask %h)",
                             id, k, got, exp_tr[id][k], exp_mask[id][k]);
                end
                if (is_wait[id][k] && is_wait[id][k-1]) begin
                    checks++;
                    if (got[7:4] !== prev_obs[id][7:4]) begin
                        errors++;
                        $display("FAIL wait_counter_stable dut%0d cycle %0d got %0d expected %0d",
                                 id, k, got[7:4], prev_obs[id][7:4]);
                    end
                end
                prev_obs[id] = got;
                if (got[1] === 1'b1) begin
                    if (id == 0) cv_q0.push_back(k); else cv_q1.push_back(k);
                end
                if (got[2] === 1'b1 && tag_cyc[id] < 0) tag_cyc[id] = k;
                if (got[0] === 1'b1 && end_cyc[id] < 0) end_cyc[id] = k;
            end
            if (k == abort_at) begin
                #2 resetb_i = 1'b0;
                #1;
                for (int id = 0; id < 2; id++) begin
                    checks++;
                    if (obs(id) !== 14'd0) begin
                        errors++;
                        $display("FAIL async_reset dut%0d got %h expected 0000", id, obs(id));
                    end
                end
                if4.start_i = 1'b0; if1.start_i = 1'b0;
                @(negedge clock_i);
                @(negedge clock_i);
                resetb_i = 1'b1;
                for (int j = 0; j < 15; j++) begin
                    @(negedge clock_i);
                    for (int id = 0; id < 2; id++) begin
                        checks++;
                        if (obs(id) !== 14'd0) begin
                            errors++;
                            $display("FAIL idle_after_reset dut%0d step %0d got %h expected 0000",
                                     id, j, obs(id));
                        end
                    end
                end
                return;
            end
            if4.start_i = (k >= sp_lo && k <= sp_hi); if1.start_i = (k >= sp_lo && k <= sp_hi);
            if4.data_valid_i = dv_seq[k]; if1.data_valid_i = dv_seq[k];
        end
        if4.start_i = 1'b0; if1.start_i = 1'b0;
    endtask

    task automatic test_reset();
        resetb_i = 1'b0;
        if4.start_i = 1'b0; if4.data_valid_i = 1'b0;
        if1.start_i = 1'b0; if1.data_valid_i = 1'b0;
        repeat (3) @(negedge clock_i);
        for (int id = 0; id < 2; id++) begin
            checks++;
            if (obs(id) !== 14'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got %h expected 0000", id, obs(id));
            end
        end
        resetb_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if4.data_valid_i = 1'($urandom_range(0, 1)); if1.data_valid_i = if4.data_valid_i;
            @(negedge clock_i);
            for (int id = 0; id < 2; id++) begin
                checks++;
                if (obs(id) !== 14'd0) begin
                    errors++;
                    $display("FAIL idle_no_start dut%0d step %0d got %h expected 0000", id, j, obs(id));
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic check_timing(input string name, input int c0, input int tag4,
                                input int tag1, input int cv1);
        int e[4];
        bit ok;
        e = '{c0, c0 + 7, c0 + 14, c0 + 21};
        ok = (cv_q0.size() == 4);
        if (ok) for (int i = 0; i < 4; i++) if (cv_q0[i] != e[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cipher_valid_cycles dut4 got %p expected %p", name, cv_q0, e);
        end
        checks++;
        if (tag_cyc[0] != tag4 || end_cyc[0] != tag4 + 1) begin
            errors++;
            $display("FAIL %s tag_end dut4 got tag %0d end %0d expected tag %0d end %0d",
                     name, tag_cyc[0], end_cyc[0], tag4, tag4 + 1);
        end
        checks++;
        if (cv_q1.size() != 1 || cv_q1[0] != cv1 || tag_cyc[1] != tag1 || end_cyc[1] != tag1 + 1) begin
            errors++;
            $display("FAIL %s dut1 got cv %p tag %0d end %0d expected cv %0d tag %0d end %0d",
                     name, cv_q1, tag_cyc[1], end_cyc[1], cv1, tag1, tag1 + 1);
        end
    endtask

    task automatic test_full_run();
        run_msg(0, 999, 0, -1, 4, -1);
        check_timing("full_run", 22, 53, 32, 22);
        $display("test_full_run done cv4=%p tag4=%0d", cv_q0, tag_cyc[0]);
    endtask

    task automatic test_end_restart();
        run_msg(0, 999, 0, -1, 3, -1);
        for (int id = 0; id < 2; id++) begin
            checks++;
            if (first_obs[id][7:4] !== 4'd0 || first_obs[id][13] !== 1'b0 ||
                first_obs[id][0] !== 1'b0 || first_obs[id][12] !== 1'b1) begin
                errors++;
                $display("FAIL end_restart dut%0d first cycle got %h expected counter 0 sel 0 end 0 reg 1",
                         id, first_obs[id]);
            end
        end
        check_timing("end_restart", 22, 53, 32, 22);
        $display("test_end_restart done");
    endtask

    task automatic test_dv_stall();
        run_msg(0, 20, 0, -1, 3, -1);
        check_timing("dv_stall", 27, 58, 37, 27);
        $display("test_dv_stall done cv4=%p tag4=%0d", cv_q0, tag_cyc[0]);
    endtask

    task automatic test_start_ignored();
        run_msg(0, 999, 15, 17, 3, -1);
        check_timing("start_ignored", 22, 53, 32, 22);
        $display("test_start_ignored done");
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 4; m++) begin
            run_msg(1, 999, 0, -1, 2, -1);
            checks++;
            if (cv_q0.size() != 4 || cv_q1.size() != 1) begin
                errors++;
                $display("FAIL b2b_pulse_count msg %0d got %0d/%0d expected 4/1",
                         m, cv_q0.size(), cv_q1.size());
            end
            $display("test_back_to_back msg %0d tag4=%0d tag1=%0d", m, tag_cyc[0], tag_cyc[1]);
        end
    endtask

    task automatic test_reset_mid_fin();
        // cycle 47 is FIN counter 5 for N_BLOCKS=4 with data_valid held high
        run_msg(0, 999, 0, -1, 4, 47);
        checks++;
        if (tag_cyc[0] != -1 || end_cyc[0] != -1) begin
            errors++;
            $display("FAIL reset_mid_fin dut4 got tag %0d end %0d expected none", tag_cyc[0], end_cyc[0]);
        end
        $display("test_reset_mid_fin done");
        run_msg(0, 999, 0, -1, 3, -1);
        check_timing("after_reset", 22, 53, 32, 22);
        $display("test_after_reset done");
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_end_restart();
        test_dv_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_fin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascon_fsm.md
ASCON_FSM -- requirements
Module: ascon_fsm

Interface
REQ-001 The block SHALL have parameter N_BLOCKS, default 4, giving the number of 64-bit plaintext blocks per message (range 1..15).
REQ-002 The block SHALL have these ports:
- clock_i  in  1  single clock, all state on rising edge.
- resetb_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin a new encryption; sampled only in IDLE or END.
- data_valid_i  in  1  next AD/plaintext block is present on the datapath data input.
- data_sel_o  out  1  0 selects external initial state, 1 selects registered state.
- en_reg_state_o  out  1  permutation state register enable.
- en_xor_data_o  out  1  XOR data into state word 0 at permutation input.
- en_xor_key_o  out  1  XOR key into state words 1-2 at permutation input.
- en_xor_lsb_o  out  1  XOR 1 into state word 4 LSB at permutation output.
- en_xor_key_end_o  out  1  XOR key into state words 3-4 at permutation output.
- counter_o  out  4  round index driven to the datapath round-constant input.
- en_cipher_o  out  1  cipher register load enable.
- en_tag_o  out  1  tag register load enable.
- cipher_valid_o  out  1  cipher register content valid, one-cycle pulse.
- end_o  out  1  encryption complete, tag valid.

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FIN, END; all outputs decoded from registered state, round counter and block counter.
REQ-004 IDLE: all outputs 0; start_i=1 -> INIT with round counter 0.
REQ-005 INIT: 12 cycles, counter_o 0..11; en_reg_state_o=1; data_sel_o=0 at counter 0, 1 otherwise; en_xor_key_end_o=1 at counter 11 only; after counter 11 -> WAIT_AD.
REQ-006 WAIT_AD / WAIT_PT: en_reg_state_o=0 (state held), other enables 0; data_valid_i=1 -> AD / PT (WAIT_PT -> FIN when the block counter equals N_BLOCKS-1), round counter loaded 6 (FIN: 0); data_valid_i=0 -> stay.
REQ-007 AD: 6 cycles, counter_o 6..11, data_sel_o=1, en_reg_state_o=1; en_xor_data_o=1 at counter 6 only; en_xor_lsb_o=1 at counter 11 only; then -> WAIT_PT (N_BLOCKS=1: -> WAIT_PT, which then goes to FIN).
REQ-008 PT: 6 cycles, counter_o 6..11, data_sel_o=1, en_reg_state_o=1; en_xor_data_o=1 and en_cipher_o=1 at counter 6 only; block counter increments at counter 11; then -> WAIT_PT.
REQ-009 FIN: 12 cycles, counter_o 0..11, data_sel_o=1, en_reg_state_o=1; at counter 0 en_xor_data_o=1, en_xor_key_o=1, en_cipher_o=1; at counter 11 en_xor_key_end_o=1, en_tag_o=1; then -> END.
REQ-010 cipher_valid_o SHALL pulse high for exactly the cycle after each en_cipher_o cycle (N_BLOCKS pulses per message).
REQ-011 END: end_o=1, all enables 0; held until start_i=1 -> INIT with round counter 0 and block counter 0.
REQ-012 start_i in INIT, WAIT_*, AD, PT, FIN SHALL be ignored; data_valid_i outside WAIT_* SHALL be ignored.
REQ-013 Round counter SHALL be 4-bit, incrementing by 1, never exceeding 11; block counter 4-bit, cleared on entry to INIT.
REQ-014 Upstream holds data_i stable from the data_valid_i sampling cycle through the following round cycle.

Reset
REQ-015 resetb_i=0 SHALL immediately force IDLE, round and block counters 0, all outputs 0, including mid-round or in END.
REQ-016 After resetb_i rises, no action SHALL occur until start_i is sampled high.

Verification (cycle k = k-th rising edge after the edge sampling start_i; N_BLOCKS=4 unless stated)
REQ-017 Full run, data_valid_i held 1: INIT cycles 1-12 (key_end at 12), WAIT_AD 13, AD 14-19 (lsb at 19), PT 21-26, 28-33, 35-40, FIN 42-53; cipher_valid_o at 22, 29, 36, 43; en_tag_o at 53; end_o from 54.
REQ-018 data_valid_i low 5 cycles in first WAIT_PT: en_reg_state_o=0 and counter_o stable throughout; every later event shifted by exactly 5 cycles.
REQ-019 resetb_i pulsed low at FIN counter 5: outputs 0 asynchronously, IDLE; no en_tag_o, no end_o.
REQ-020 start_i pulsed during AD: no effect; run completes with REQ-017 timing.
REQ-021 In END, start_i=1: next cycle INIT, counter_o=0, data_sel_o=0, end_o=0.
REQ-022 N_BLOCKS=1: INIT, WAIT_AD, AD, WAIT_PT, FIN directly; single cipher_valid_o pulse at FIN counter 0 + 1 cycle; en_tag_o at FIN counter 11.
